dt_serial_walker: RTL



---
 rtl/dt_serial_walker_if.sv | 30 +++
 rtl/dt_serial_walker.sv | 130 +++++++++++++
 2 files changed

// File: rtl/dt_serial_walker_if.sv
// Bundle of the node-table write port and the feature/result streams of dt_serial_walker.
// The slave modport is the walker's view; the master modport is the host/source/consumer view.
interface dt_serial_walker_if #(
  parameter int N  = 8,
  parameter int C  = 1,
  parameter int AW = 6,
  parameter int W  = 26
);
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [W-1:0]  cfg_wdata;
  logic          cfg_busy;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_feat;
  logic          out_valid;
  logic          out_ready;
  logic [C-1:0]  out_cls;
  logic          out_err;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, in_valid, in_feat, out_ready,
    input  cfg_busy, in_ready, out_valid, out_cls, out_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_feat, out_ready,
    output cfg_busy, in_ready, out_valid, out_cls, out_err
  );
endinterface

// File: rtl/dt_serial_walker.sv
// Sequential decision-tree engine: collects one feature sample, then walks a
// programmable node table one node per cycle through a single shared comparator.
module dt_serial_walker #(
  parameter int N         = 8,
  parameter int F         = 30,
  parameter int C         = 1,
  parameter int NODES     = 64,
  parameter int MAX_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  dt_serial_walker_if.slave  bus
);
  localparam int FW = $clog2(F);
  localparam int AW = $clog2(NODES);
  localparam int W  = 1 + FW + N + 2 * AW;
  localparam int DW = $clog2(MAX_DEPTH + 1);

  typedef enum logic [1:0] {LOAD, WALK, DONE} state_t;

  state_t        state;
  logic [FW-1:0] cnt;
  logic [AW-1:0] node;
  logic [DW-1:0] depth;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [C-1:0]  out_cls_q;
  logic          out_err_q;

  logic [W-1:0]  node_table [NODES];
  logic [N-1:0]  feat [2**FW];

  logic [W-1:0]  word;
  logic          leaf;
  logic [FW-1:0] feat_idx;
  logic [N-1:0]  thr;
  logic [AW-1:0] left;
  logic [AW-1:0] right;
  logic          beat;
  logic          cfg_ok;
  logic          bad_idx;

  assign word     = node_table[node];
  assign leaf     = word[W-1];
  assign feat_idx = word[W-2 -: FW];
  assign thr      = word[2*AW+N-1 -: N];
  assign left     = word[2*AW-1 -: AW];
  assign right    = word[AW-1:0];
  assign bad_idx  = int'(feat_idx) >= F;

  // in_ready_q is high exactly in LOAD, so it doubles as the state decode here
  assign beat   = bus.in_valid & in_ready_q;
  assign cfg_ok = in_ready_q & (cnt == '0);

  assign bus.cfg_busy  = ~cfg_ok;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_cls   = out_cls_q;
  assign bus.out_err   = out_err_q;

  // Table and feature storage are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (bus.cfg_we && cfg_ok) begin
      node_table[bus.cfg_addr] <= bus.cfg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      feat[cnt] <= bus.in_feat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      cnt         <= '0;
      node        <= '0;
      depth       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_cls_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (beat) begin
            if (cnt == FW'(F - 1)) begin
              cnt        <= '0;
              node       <= '0;
              depth      <= '0;
              in_ready_q <= 1'b0;
              state      <= WALK;
            end else begin
              cnt <= cnt + FW'(1);
            end
          end
        end
        WALK: begin
          if (leaf) begin
            out_cls_q   <= thr[C-1:0];
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else if (bad_idx || depth == DW'(MAX_DEPTH - 1)) begin
            out_cls_q   <= '0;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            node  <= (feat[feat_idx] < thr) ? left : right;
            depth <= depth + DW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= LOAD;
          end
        end
        default: begin
          state       <= LOAD;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule
